// File: rtl/psu_seq_core.sv
// N-rail power-supply sequencer: ascending power-up with per-rail delays and power-good waits,
// reverse-order power-down, and latched PG-timeout / PG-loss faults that drop every rail at once.
module psu_seq_core #(
   parameter int N_RAILS    = 4,
   parameter int DLY_W      = 8,
   parameter int DLY_RST    = 16,
   parameter int PG_TIMEOUT = 200
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               start,
   input  logic               stop,
   input  logic               fault_clr,
   input  logic [N_RAILS-1:0] pg,
   input  logic               cfg_we,
   input  logic [2:0]         cfg_addr,
   input  logic [DLY_W-1:0]   cfg_data,
   output logic [N_RAILS-1:0] rail_en,
   output logic               pwr_ok,
   output logic               busy,
   output logic               fault,
   output logic [2:0]         fault_rail,
   output logic [1:0]         fault_code
);

   typedef enum logic [2:0] {IDLE, UP_DLY, UP_PG, ON, DN_DLY, FAULT} state_t;

   localparam int             TW        = (PG_TIMEOUT > 1) ? $clog2(PG_TIMEOUT) : 1;
   localparam logic [2:0]     LAST      = 3'(N_RAILS - 1);
   localparam logic [TW-1:0]  T_LAST    = TW'(PG_TIMEOUT - 1);
   localparam logic [1:0]     CODE_NONE = 2'd0;
   localparam logic [1:0]     CODE_TMO  = 2'd1;
   localparam logic [1:0]     CODE_LOSS = 2'd2;

   state_t                          state, state_nxt;
   logic [2:0]                      idx, idx_nxt;
   logic [DLY_W-1:0]                cnt, cnt_nxt;
   logic [TW-1:0]                   tcnt, tcnt_nxt;
   logic [N_RAILS-1:0]              rail_en_nxt;
   logic [2:0]                      frail_nxt;
   logic [1:0]                      code_nxt;
   logic [N_RAILS-1:0][DLY_W-1:0]   dly;

   logic [N_RAILS-1:0] idx_oh;
   logic [N_RAILS-1:0] loss_vec;
   logic [2:0]         loss_rail;
   logic               pg_idx;
   logic               mon;

   function automatic logic [DLY_W-1:0] dly_at(input logic [N_RAILS-1:0][DLY_W-1:0] tbl,
                                               input logic [2:0] k);
      logic [DLY_W-1:0] r;
      r = '0;
      for (int i = 0; i < N_RAILS; i++)
         if (k == 3'(i)) r = tbl[i];
      return r;
   endfunction

   assign idx_oh = N_RAILS'(1) << idx;
   assign pg_idx = |(pg & idx_oh);
   assign mon    = (state == UP_DLY) || (state == UP_PG) || (state == ON);
   // The rail still waiting for its first power-good is not a loss candidate.
   assign loss_vec = rail_en & ~pg & ((state == UP_PG) ? ~idx_oh : {N_RAILS{1'b1}});

   always_comb begin
      loss_rail = '0;
      for (int j = N_RAILS - 1; j >= 0; j--)
         if (loss_vec[j]) loss_rail = 3'(j);
   end

   // Delay registers: writable only while idle, out-of-range addresses fall through.
   // NOTE: this is a handful of flops, not a RAM, so it takes the reset value like any other state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_RAILS; i++) dly[i] <= DLY_W'(DLY_RST);
      end else if (cfg_we && state == IDLE) begin
         for (int i = 0; i < N_RAILS; i++)
            if (cfg_addr == 3'(i)) dly[i] <= cfg_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         tcnt       <= '0;
         rail_en    <= '0;
         fault_rail <= '0;
         fault_code <= CODE_NONE;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         tcnt       <= tcnt_nxt;
         rail_en    <= rail_en_nxt;
         fault_rail <= frail_nxt;
         fault_code <= code_nxt;
      end
   end

   // NOTE: every variable gets a hold default up front so no branch can infer a latch.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      cnt_nxt     = cnt;
      tcnt_nxt    = tcnt;
      rail_en_nxt = rail_en;
      frail_nxt   = fault_rail;
      code_nxt    = fault_code;
      if (mon && |loss_vec) begin
         state_nxt   = FAULT;
         rail_en_nxt = '0;
         code_nxt    = CODE_LOSS;
         frail_nxt   = loss_rail;
      end else if (state == UP_PG && !pg_idx && tcnt == T_LAST) begin
         state_nxt   = FAULT;
         rail_en_nxt = '0;
         code_nxt    = CODE_TMO;
         frail_nxt   = idx;
      end else begin
         case (state)
            IDLE: if (start && ena && !stop) begin
               state_nxt = UP_DLY;
               idx_nxt   = '0;
               cnt_nxt   = dly_at(dly, 3'd0);
            end
            UP_DLY: if (stop) begin
               if (idx == 3'd0) state_nxt = IDLE;
               else begin
                  state_nxt = DN_DLY;
                  idx_nxt   = idx - 3'd1;
                  cnt_nxt   = dly_at(dly, idx - 3'd1);
               end
            end else if (cnt != '0) cnt_nxt = cnt - 1'b1;
            else begin
               rail_en_nxt = rail_en | idx_oh;
               tcnt_nxt    = '0;
               state_nxt   = UP_PG;
            end
            UP_PG: if (stop) begin
               state_nxt = DN_DLY;
               cnt_nxt   = dly_at(dly, idx);
            end else if (pg_idx) begin
               if (idx == LAST) state_nxt = ON;
               else begin
                  state_nxt = UP_DLY;
                  idx_nxt   = idx + 3'd1;
                  cnt_nxt   = dly_at(dly, idx + 3'd1);
               end
            end else tcnt_nxt = tcnt + 1'b1;
            ON: if (stop) begin
               state_nxt = DN_DLY;
               idx_nxt   = LAST;
               cnt_nxt   = dly_at(dly, LAST);
            end
            DN_DLY: if (cnt != '0) cnt_nxt = cnt - 1'b1;
            else begin
               rail_en_nxt = rail_en & ~idx_oh;
               if (idx == 3'd0) state_nxt = IDLE;
               else begin
                  idx_nxt = idx - 3'd1;
                  cnt_nxt = dly_at(dly, idx - 3'd1);
               end
            end
            FAULT: if (fault_clr) begin
               state_nxt = IDLE;
               code_nxt  = CODE_NONE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      pwr_ok = (state == ON);
      busy   = (state == UP_DLY) || (state == UP_PG) || (state == DN_DLY);
      fault  = (state == FAULT);
   end

endmodule

// File: tb/tb_psu_seq_core.sv
// Directed bench for psu_seq_core: power-up/down timing, faults, abort, cfg gating and reset.
// pg[i] follows rail_en[i] through a 4-flop pipe, so the sequencer sees it 5 edges after the enable.
module tb_psu_seq_core;

   logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0, stop = 1'b0;
   logic       fault_clr = 1'b0, cfg_we = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic [3:0] pg, rail_en, pg_kill = '0;
   logic [3:0][3:0] pipe = '0;
   logic       pwr_ok, busy, fault;
   logic [2:0] fault_rail;
   logic [1:0] fault_code;

   int checks = 0, failures = 0;
   int ch_t[$];
   logic [3:0] ch_v[$];
   int t_ok, t_fault;

   psu_seq_core dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop), .fault_clr(fault_clr),
      .pg(pg), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .rail_en(rail_en), .pwr_ok(pwr_ok), .busy(busy), .fault(fault),
      .fault_rail(fault_rail), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) pipe <= {pipe[2:0], rail_en};
   assign pg = pipe[3] & ~pg_kill;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs ncyc edges, logging every rail_en change with its edge number (1 = first edge after call).
   task automatic watch(input int ncyc);
      logic [3:0] prev;
      prev = rail_en;
      ch_t.delete();
      ch_v.delete();
      t_ok = -1;
      t_fault = -1;
      for (int c = 1; c <= ncyc; c++) begin
         tick();
         if (rail_en != prev) begin
            ch_t.push_back(c);
            ch_v.push_back(rail_en);
            prev = rail_en;
         end
         if (pwr_ok && t_ok < 0) t_ok = c;
         if (fault && t_fault < 0) t_fault = c;
      end
   endtask

   task automatic expect_steps(input string tag, input int n, input int et[4], input int ev[4]);
      check($sformatf("%s nsteps", tag), ch_t.size(), n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s t%0d", tag, i), (i < ch_t.size()) ? ch_t[i] : -1, et[i]);
         check($sformatf("%s v%0d", tag, i), (i < ch_v.size()) ? int'(ch_v[i]) : -1, ev[i]);
      end
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("rst rail_en", rail_en, 0);
      check("rst fault", fault, 0);
      check("rst code", fault_code, 0);
      check("rst frail", fault_rail, 0);
      check("rst pwr_ok", pwr_ok, 0);
      check("rst busy", busy, 0);

      // dly = {2,0,5,3}; address 5 does not exist and must not alias onto rail 1
      cfg_write(3'd0, 8'd2);
      cfg_write(3'd1, 8'd0);
      cfg_write(3'd2, 8'd5);
      cfg_write(3'd3, 8'd3);
      cfg_write(3'd5, 8'd9);

      // Power-up: enables at E0+3,+9,+20,+29, pwr_ok at E0+34
      pulse_start();
      watch(40);
      expect_steps("up", 4, '{3, 9, 20, 29}, '{1, 3, 7, 15});
      check("up t_ok", t_ok, 34);
      check("up busy", busy, 0);

      // Write in ON must be dropped: rail 3 still uses delay 3 on the way down
      cfg_write(3'd3, 8'd50);

      // Power-down from edge S0: drops at S0+4,+10,+11,+14
      stop = 1'b1;
      tick();
      stop = 1'b0;
      watch(20);
      expect_steps("dn", 4, '{4, 10, 11, 14}, '{7, 3, 1, 0});
      check("dn busy", busy, 0);
      check("dn pwr_ok", pwr_ok, 0);

      // start together with stop, and start with ena low, both stay idle
      repeat (6) tick();
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      tick();
      check("ss busy", busy, 0);
      check("ss rail_en", rail_en, 0);
      ena = 1'b0;
      pulse_start();
      ena = 1'b1;
      tick();
      check("ena busy", busy, 0);

      // pg[2] never rises: rail 2 up at 20, timeout fault 200 edges later
      pg_kill = 4'b0100;
      pulse_start();
      watch(225);
      expect_steps("tmo", 4, '{3, 9, 20, 220}, '{1, 3, 7, 0});
      check("tmo t_fault", t_fault, 220);
      check("tmo code", fault_code, 1);
      check("tmo frail", fault_rail, 2);
      pulse_start();
      tick();
      check("tmo start ign", fault, 1);
      check("tmo start rail", rail_en, 0);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      pg_kill = 4'b0000;
      check("clr fault", fault, 0);
      check("clr code", fault_code, 0);
      check("clr frail kept", fault_rail, 2);
      check("clr busy", busy, 0);

      // pg[1] glitches low for one cycle while ON
      repeat (6) tick();
      pulse_start();
      watch(40);
      check("loss on", pwr_ok, 1);
      pg_kill = 4'b0010;
      tick();
      pg_kill = 4'b0000;
      check("loss fault", fault, 1);
      check("loss code", fault_code, 2);
      check("loss frail", fault_rail, 1);
      check("loss rail_en", rail_en, 0);
      pulse_start();
      tick();
      check("loss start ign", fault, 1);
      check("loss start busy", busy, 0);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("loss clr", fault, 0);

      // Abort while rail 2 counts its delay: rail 1 drops at S0+1, rail 0 at S0+4
      repeat (6) tick();
      pulse_start();
      watch(16);
      check("abort pre", rail_en, 3);
      check("abort pre busy", busy, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      watch(8);
      expect_steps("abort", 2, '{1, 4, 0, 0}, '{1, 0, 0, 0});
      check("abort busy", busy, 0);

      // Reset mid power-up clears rails on that edge and restores delay 16
      repeat (6) tick();
      pulse_start();
      watch(12);
      check("rstm pre", rail_en, 3);
      rst_n = 1'b0;
      tick();
      check("rstm rail_en", rail_en, 0);
      check("rstm busy", busy, 0);
      rst_n = 1'b1;
      pulse_start();
      watch(20);
      expect_steps("rstm dly", 1, '{17, 0, 0, 0}, '{1, 0, 0, 0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
